// File: rtl/edge_mask_tx_pkg.sv
// Shared constants and commit-state encoding for the edge-mask beat stream.
// The receiver side imports the same package so both ends agree on framing.
package edge_mask_tx_pkg;

    localparam int WORD_W          = 32;
    localparam int BEAT_W          = 128;
    localparam int BEATS           = 16;
    localparam int FRAME_W         = BEAT_W * BEATS;
    localparam int WORDS_PER_FRAME = FRAME_W / WORD_W;

    localparam int SEL_W  = $clog2(BEATS);
    localparam int ADDR_W = $clog2(WORDS_PER_FRAME);
    localparam int CNT_W  = 16;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(BEATS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } commit_state_t;

endpackage

// File: rtl/edge_mask_tx_beat_mux.sv
// Beat selector: beat 0 is taken from the top of the frame because the
// receiver shifts the first beat it loads up to the top of its map.
module edge_mask_beat_mux
    import edge_mask_tx_pkg::*;
(
    input  logic [FRAME_W-1:0] frame,
    input  logic [SEL_W-1:0]   sel,
    output logic [BEAT_W-1:0]  beat
);

    always_comb begin
        beat = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (sel == SEL_W'(i)) begin
                beat = frame[(BEATS - 1 - i) * BEAT_W +: BEAT_W];
            end
        end
    end

endmodule

// File: rtl/edge_mask_tx.sv
// Edge-mask source: word-addressed shadow map, frame-aligned commit into the
// active map, beat output indexed by the receiver, plus frame/sequence tracking.
module edge_mask_tx
    import edge_mask_tx_pkg::*;
(
    input  logic                CLK,
    input  logic                RST_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WORD_W-1:0]   wr_data,
    output logic                wr_ready,
    input  logic                clr_shadow,
    input  logic                commit,
    output logic                commit_pending,
    input  logic [SEL_W-1:0]    data_sel,
    output logic [BEAT_W-1:0]   edge_mask,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic                seq_err,
    input  logic                clr_err
);

    commit_state_t      state, state_next;
    logic [FRAME_W-1:0] shadow, shadow_next;
    logic [FRAME_W-1:0] active;
    logic [SEL_W-1:0]   expected_sel;
    logic               last_beat;
    logic               do_swap;

    assign last_beat = (data_sel == LAST_SEL);

    // Shadow edits are only possible while no commit is waiting, so a pending
    // frame can never change underneath the swap.
    always_comb begin
        shadow_next = shadow;
        if (state == ST_IDLE) begin
            if (clr_shadow) begin
                shadow_next = '0;
            end else if (wr_en) begin
                shadow_next[int'(wr_addr) * WORD_W +: WORD_W] = wr_data;
            end
        end
    end

    always_comb begin
        state_next     = state;
        do_swap        = 1'b0;
        wr_ready       = (state == ST_IDLE);
        commit_pending = (state == ST_PEND);
        unique case (state)
            ST_IDLE: begin
                if (commit) begin
                    if (last_beat) begin
                        do_swap = 1'b1;
                    end else begin
                        state_next = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (last_beat) begin
                    do_swap    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Swapping from shadow_next lets a same-cycle write join the commit.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state  <= ST_IDLE;
            shadow <= '0;
            active <= '0;
        end else begin
            state  <= state_next;
            shadow <= shadow_next;
            if (do_swap) begin
                active <= shadow_next;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            frame_cnt    <= '0;
            expected_sel <= '0;
            seq_err      <= 1'b0;
        end else begin
            if (last_beat) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            expected_sel <= data_sel + 1'b1;
            if (data_sel != expected_sel) begin
                seq_err <= 1'b1;
            end else if (clr_err) begin
                seq_err <= 1'b0;
            end
        end
    end

    edge_mask_beat_mux u_beat_mux (
        .frame (active),
        .sel   (data_sel),
        .beat  (edge_mask)
    );

endmodule

// File: doc/edge_mask_tx.md
Name: edge_mask_tx

Overview:
- Source end of the 128-bit edge-mask beat stream.
- Software/test logic loads a 2048-bit edge map as 64 words of 32 bits into a shadow buffer, then commits it.
- The block presents the committed map as 16 beats of 128 bits on edge_mask, indexed by the data_sel counter driven by the accumulating receiver.
- Commits swap in only on a frame boundary, so the receiver never sees a mixed frame.

Parameters:
WORD_W, 32, write word width
BEAT_W, 128, edge_mask beat width
BEATS, 16, beats per frame (data_sel range 0..BEATS-1)
FRAME_W, 2048, BEAT_W*BEATS; map size (64 words)

Ports:
CLK  in  1  clock, rising edge
RST_n  in  1  reset, asynchronous, active-low
wr_en  in  1  word write strobe, accepted when wr_en & wr_ready
wr_addr  in  6  word index n; word n occupies shadow bits [n*32+31 : n*32]
wr_data  in  32  word data
wr_ready  out  1  high when shadow is writable (no commit pending)
clr_shadow  in  1  pulse: zero entire shadow buffer
commit  in  1  pulse: request shadow->active copy at next frame boundary
commit_pending  out  1  commit requested, not yet applied
data_sel  in  4  beat index from receiver
edge_mask  out  128  beat data for current data_sel
frame_cnt  out  16  frames completed since reset
seq_err  out  1  sticky: data_sel did not advance by +1 mod 16
clr_err  in  1  pulse: clear seq_err

Behaviour:
- Reset (async assert, sync release): shadow=0, active=0, commit_pending=0, frame_cnt=0, seq_err=0, expected_sel=0. Hence wr_ready=1 and edge_mask=0 during reset.
- Beat ordering: the receiver loads beat 0 first and shifts it to the top of its frame.
  - edge_mask = active[(15-data_sel)*128 +: 128], a pure combinational mux of registered active; zero-cycle latency from data_sel.
  - Net effect: word n written here lands at receiver map bits [n*32 +: 32].
- Write: on wr_en & wr_ready, shadow word wr_addr <= wr_data next edge. wr_en while wr_ready=0 is dropped silently.
- clr_shadow: zeroes shadow next edge; takes priority over a same-cycle write; ignored while commit_pending=1.
- Commit FSM (2 states):
  - IDLE: wr_ready=1. commit -> PEND (commit_pending=1). A write in the same cycle as commit is included in the commit.
  - PEND: wr_ready=0; further commit pulses ignored. On the edge where data_sel==15: active <= shadow, go to IDLE. The next frame (data_sel 0..15) is entirely new data.
- Frame counter: increments on every edge where data_sel==15; wraps 0xFFFF->0.
- Sequence check:
  - expected_sel <= data_sel+1 (mod 16) each cycle.
  - If data_sel != expected_sel, seq_err <= 1 (sticky).
  - clr_err clears it; a mismatch in the same cycle wins (stays 1).
- Reset mid-PEND: pending discarded, active=0; shadow contents lost.
- Shadow is not altered by a swap (it keeps its data for incremental edits).

Decomposition:
- Shared package: WORD_W, BEAT_W, BEATS, FRAME_W, WORDS_PER_FRAME=64, and the IDLE/PEND state encoding. The receiver uses the same constants.
- One natural sub-module, edge_mask_beat_mux: combinational 16:1 x 128-bit selector with the reversed index. Buffers, FSM and checks stay at top level.

Test Plan:
1. Reset, data_sel free-running 0..15 -> edge_mask=0 every beat; frame_cnt +1 per 16 cycles; seq_err=0.
2. Write word 0=0xDEADBEEF, word 63=0x12345678, commit during data_sel=5:
   - commit_pending=1 until the data_sel=15 edge.
   - Next frame: data_sel=15 beat[31:0]=0xDEADBEEF; data_sel=0 beat[127:96]=0x12345678.
   - Receiver model reproduces both words at bits [31:0] and [2047:2016].
3. While pending, wr_en with addr 1, data 0xFFFFFFFF -> wr_ready=0, write dropped; after swap, word 1 reads 0 in active.
4. commit coincident with data_sel=15 -> swap happens at that edge (same cycle), commit_pending pulses 1 for one cycle or not at all per FSM timing; verify frame starting next cycle is new.
5. Drive data_sel 3 then 5 -> seq_err=1 and stays 1; clr_err -> 0; clr_err concurrent with a new skip -> stays 1.
6. Assert RST_n low mid-PEND at data_sel=9 -> immediately edge_mask=0, commit_pending=0, wr_ready=1.
